// File: rtl/ica_demix_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : ica_demix_stream_if
// Description : Sample-load, weight-load, control and demixed-output bus for
//               the ICA demix stream stage.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface ica_demix_stream_if #(
    parameter int NCH = 4,
    parameter int DW  = 26,
    parameter int AW  = 7,
    parameter int WAW = 4
);
    logic                z_valid;
    logic                z_ready;
    logic [NCH*DW-1:0]   z_data;
    logic                buf_clr;
    logic [AW:0]         buf_cnt;
    logic                buf_full;
    logic                w_we;
    logic [WAW-1:0]      w_addr;
    logic [DW-1:0]       w_data;
    logic                go_demix;
    logic                demix_busy;
    logic                y_valid;
    logic                y_ready;
    logic [NCH*DW-1:0]   y_data;
    logic [AW-1:0]       y_idx;
    logic                sat_flag;

    // Controller / producer / consumer side
    modport master (
        output z_valid, z_data, buf_clr, w_we, w_addr, w_data, go_demix, y_ready,
        input  z_ready, buf_cnt, buf_full, demix_busy, y_valid, y_data, y_idx, sat_flag
    );

    // Demix engine side
    modport slave (
        input  z_valid, z_data, buf_clr, w_we, w_addr, w_data, go_demix, y_ready,
        output z_ready, buf_cnt, buf_full, demix_busy, y_valid, y_data, y_idx, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/ica_demix_stream.sv
`default_nettype none
// ============================================================================
// Module      : ica_demix_stream
// Description : Buffers a block of NCH-channel whitened samples and streams
//               y = W*z per sample with a single time-shared signed multiplier.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module ica_demix_stream #(
    parameter int NCH   = 4,
    parameter int DEPTH = 128,
    parameter int DW    = 26,
    parameter int FRAC  = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int WAW   = $clog2(NCH*NCH)
) (
    input  logic                  clk_demix,
    input  logic                  rst_demix,
    ica_demix_stream_if.slave     bus
);
    localparam int NN   = NCH * NCH;
    localparam int LG   = $clog2(NCH);
    localparam int ACCW = 2 * DW + LG;
    localparam int CW   = $clog2(NCH);
    localparam int KW   = WAW + 1;
    localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [AW:0]             r_cnt;
    logic [NCH*DW-1:0]       r_mem [0:DEPTH-1];
    logic signed [DW-1:0]    r_w   [0:NN-1];
    logic [AW-1:0]           r_idx;
    logic [KW-1:0]           r_k;
    logic [CW-1:0]           r_row;
    logic [CW-1:0]           r_col;
    logic signed [ACCW-1:0]  r_acc [0:NCH-1];
    logic [NCH*DW-1:0]       r_y_data;
    logic [AW-1:0]           r_y_idx;
    logic                    r_y_valid;
    logic                    r_sat;

    logic                    w_idle;
    logic                    w_full;
    logic                    w_zacc;
    logic                    w_go;
    logic                    w_mac_done;
    logic                    w_hs;
    logic                    w_last;
    logic [NCH*DW-1:0]       w_zword;
    logic signed [DW-1:0]    w_wsel;
    logic signed [DW-1:0]    w_zsel;
    logic signed [2*DW-1:0]  w_prod;
    logic signed [ACCW-1:0]  w_sh [0:NCH-1];
    logic [NCH*DW-1:0]       w_y;
    logic                    w_sat_any;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_full     = (r_cnt == (AW+1)'(DEPTH));
    // Clear beats a concurrent sample write and a concurrent start request.
    assign w_zacc     = w_idle && bus.z_valid && !w_full && !bus.buf_clr;
    assign w_go       = w_idle && bus.go_demix && !bus.buf_clr && ((r_cnt != '0) || w_zacc);
    assign w_mac_done = (r_state == ST_MAC) && (r_k == KW'(NN));
    assign w_hs       = (r_state == ST_HOLD) && bus.y_ready;
    assign w_last     = ({1'b0, r_idx} == (r_cnt - (AW+1)'(1)));

    // Single shared multiplier: weight addressed directly by the step count
    assign w_zword = r_mem[r_idx];
    assign w_wsel  = r_w[r_k[WAW-1:0]];
    assign w_zsel  = $signed(w_zword[DW*int'(r_col) +: DW]);
    assign w_prod  = w_wsel * w_zsel;

    // Scale back by FRAC (floor) and clamp each channel to the DW range
    always_comb begin
        w_y       = '0;
        w_sat_any = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_sh[i] = r_acc[i] >>> FRAC;
            if (w_sh[i] > YMAX) begin
                w_y[i*DW +: DW] = YMAX[DW-1:0];
                w_sat_any       = 1'b1;
            end else if (w_sh[i] < YMIN) begin
                w_y[i*DW +: DW] = YMIN[DW-1:0];
                w_sat_any       = 1'b1;
            end else begin
                w_y[i*DW +: DW] = w_sh[i][DW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk_demix) begin
        if (rst_demix) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_go)       w_next = ST_MAC;
            ST_MAC:  if (w_mac_done) w_next = ST_HOLD;
            ST_HOLD: if (w_hs)       w_next = w_last ? ST_IDLE : ST_MAC;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // Sample memory; contents survive reset and passes
    always_ff @(posedge clk_demix) begin
        if (w_zacc) r_mem[r_cnt[AW-1:0]] <= bus.z_data;
    end

    // Buffer count, weights, MAC sequencing and output registers
    always_ff @(posedge clk_demix) begin
        if (rst_demix) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_k       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_y_data  <= '0;
            r_y_idx   <= '0;
            r_y_valid <= 1'b0;
            r_sat     <= 1'b0;
            for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
            for (int j = 0; j < NN; j++)
                r_w[j] <= (j % (NCH + 1) == 0) ? DW'(64'd1 << FRAC) : '0;
        end else begin
            if (w_idle && bus.w_we) r_w[bus.w_addr] <= bus.w_data;

            if (w_idle && bus.buf_clr) r_cnt <= '0;
            else if (w_zacc)           r_cnt <= r_cnt + (AW+1)'(1);

            if (w_go) begin
                r_sat <= 1'b0;
                r_idx <= '0;
                r_k   <= '0;
                r_row <= '0;
                r_col <= '0;
                for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
            end

            if (r_state == ST_MAC) begin
                if (!w_mac_done) begin
                    r_acc[r_row] <= r_acc[r_row] + {{LG{w_prod[2*DW-1]}}, w_prod};
                    r_k          <= r_k + KW'(1);
                    if (r_col == CW'(NCH - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + CW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end else begin
                    r_y_data  <= w_y;
                    r_y_idx   <= r_idx;
                    r_y_valid <= 1'b1;
                    if (w_sat_any) r_sat <= 1'b1;
                end
            end

            if (w_hs) begin
                r_y_valid <= 1'b0;
                if (!w_last) begin
                    r_idx <= r_idx + AW'(1);
                    r_k   <= '0;
                    r_row <= '0;
                    r_col <= '0;
                    for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
                end
            end
        end
    end

    assign bus.z_ready    = w_idle && !w_full;
    assign bus.buf_cnt    = r_cnt;
    assign bus.buf_full   = w_full;
    assign bus.demix_busy = !w_idle;
    assign bus.y_valid    = r_y_valid;
    assign bus.y_data     = r_y_data;
    assign bus.y_idx      = r_y_idx;
    assign bus.sat_flag   = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_ica_demix_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_ica_demix_stream
// Description : Directed self-checking bench for ica_demix_stream (NCH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ica_demix_stream;
    localparam int NCH   = 4;
    localparam int DEPTH = 128;
    localparam int DW    = 26;
    localparam int FRAC  = 16;
    localparam int AW    = 7;
    localparam int WAW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    ica_demix_stream_if #(.NCH(NCH), .DW(DW), .AW(AW), .WAW(WAW)) bus ();

    ica_demix_stream #(
        .NCH(NCH), .DEPTH(DEPTH), .DW(DW), .FRAC(FRAC), .AW(AW), .WAW(WAW)
    ) dut (
        .clk_demix (clk),
        .rst_demix (rst),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] pk(input longint a, input longint b, input longint c, input longint d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic signed [63:0] ych(input int i);
        logic signed [DW-1:0] v;
        v = bus.y_data[i*DW +: DW];
        return 64'(v);
    endfunction

    task automatic push(input logic [NCH*DW-1:0] z);
        bus.z_data  = z;
        bus.z_valid = 1'b1;
        tick();
        bus.z_valid = 1'b0;
    endtask

    task automatic wreg(input int addr, input longint val);
        bus.w_we   = 1'b1;
        bus.w_addr = WAW'(addr);
        bus.w_data = DW'(val);
        tick();
        bus.w_we   = 1'b0;
    endtask

    task automatic go();
        bus.go_demix = 1'b1;
        tick();
        bus.go_demix = 1'b0;
    endtask

    task automatic clr();
        bus.buf_clr = 1'b1;
        tick();
        bus.buf_clr = 1'b0;
    endtask

    // Returns edges waited; an expired bound shows up as a failed valid check
    task automatic wait_valid(input string tag, output int cnt);
        cnt = 0;
        while (!bus.y_valid && cnt < 200) begin
            tick();
            cnt++;
        end
        chk(tag, bus.y_valid, 1);
    endtask

    task automatic handshake();
        bus.y_ready = 1'b1;
        tick();
        bus.y_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.z_valid = 0; bus.z_data = '0; bus.buf_clr = 0; bus.w_we = 0;
        bus.w_addr = '0; bus.w_data = '0; bus.go_demix = 0; bus.y_ready = 0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_z_ready", bus.z_ready, 1);
        chk("rst_buf_cnt", bus.buf_cnt, 0);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_busy", bus.demix_busy, 0);
        chk("rst_sat", bus.sat_flag, 0);
        chk("rst_y_data", bus.y_data == '0, 1);

        // Identity pass; third sample arrives on the same edge as go
        push(pk(65536, -32768, 16384, 0));
        push(pk(65536, -32768, 16384, 0));
        bus.z_data = pk(65536, -32768, 16384, 0);
        bus.z_valid = 1'b1; bus.go_demix = 1'b1;
        tick();
        bus.z_valid = 1'b0; bus.go_demix = 1'b0;
        chk("id_cnt", bus.buf_cnt, 3);
        chk("id_busy", bus.demix_busy, 1);
        for (int s = 0; s < 3; s++) begin
            wait_valid("id_valid", n);
            chk("id_latency", n, 17);
            chk("id_y0", ych(0), 65536);
            chk("id_y1", ych(1), -32768);
            chk("id_y2", ych(2), 16384);
            chk("id_y3", ych(3), 0);
            chk("id_idx", bus.y_idx, s);
            handshake();
            chk("id_valid_drop", bus.y_valid, 0);
        end
        chk("id_busy_end", bus.demix_busy, 0);

        // W[0][1]=2.0 written on the same edge as go
        clr();
        push(pk(65536, 32768, 0, 0));
        bus.w_we = 1'b1; bus.w_addr = 4'd1; bus.w_data = DW'(131072);
        bus.go_demix = 1'b1;
        tick();
        bus.w_we = 1'b0; bus.go_demix = 1'b0;
        wait_valid("mix_valid", n);
        chk("mix_y0", ych(0), 131072);
        chk("mix_y1", ych(1), 32768);
        chk("mix_y2", ych(2), 0);
        chk("mix_y3", ych(3), 0);
        chk("mix_sat", bus.sat_flag, 0);
        handshake();

        // Clear together with go: go ignored
        bus.buf_clr = 1'b1; bus.go_demix = 1'b1;
        tick();
        bus.buf_clr = 1'b0; bus.go_demix = 1'b0;
        chk("clrgo_busy", bus.demix_busy, 0);
        chk("clrgo_cnt", bus.buf_cnt, 0);

        // Backpressure on sample 0
        push(pk(65536, 32768, 0, 0));
        push(pk(0, 65536, 0, 0));
        go();
        wait_valid("bp_valid", n);
        chk("bp_latency", n, 17);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", bus.y_valid, 1);
            chk("bp_hold_y0", ych(0), 131072);
            chk("bp_hold_y1", ych(1), 32768);
            chk("bp_hold_idx", bus.y_idx, 0);
        end
        handshake();
        wait_valid("bp_valid1", n);
        chk("bp_latency1", n, 17);
        chk("bp_s1_y0", ych(0), 131072);
        chk("bp_s1_y1", ych(1), 65536);
        chk("bp_s1_idx", bus.y_idx, 1);
        handshake();
        chk("bp_busy_end", bus.demix_busy, 0);

        // Fill past capacity; extra samples must not overwrite
        wreg(1, 0);
        clr();
        for (int i = 0; i < DEPTH; i++) push(pk(i, -i, 1000, 7));
        chk("full_z_ready", bus.z_ready, 0);
        chk("full_flag", bus.buf_full, 1);
        chk("full_cnt", bus.buf_cnt, 128);
        push(pk(5000, 5000, 5000, 5000));
        push(pk(6000, 6000, 6000, 6000));
        chk("full_cnt_after", bus.buf_cnt, 128);
        go();
        bus.y_ready = 1'b1;
        for (int s = 0; s < DEPTH; s++) begin
            wait_valid("full_valid", n);
            chk("full_idx", bus.y_idx, s);
            chk("full_y0", ych(0), s);
            chk("full_y1", ych(1), -s);
            tick();
        end
        bus.y_ready = 1'b0;
        chk("full_busy_end", bus.demix_busy, 0);

        // Positive and negative saturation, sticky flag cleared by next go
        clr();
        wreg(0, 33554431);
        push(pk(33554431, 0, 0, 0));
        go();
        wait_valid("satp_valid", n);
        chk("satp_y0", ych(0), 33554431);
        chk("satp_y1", ych(1), 0);
        chk("satp_flag", bus.sat_flag, 1);
        handshake();
        chk("satp_sticky", bus.sat_flag, 1);
        clr();
        push(pk(-33554431, 0, 0, 0));
        go();
        chk("satn_flag_clr", bus.sat_flag, 0);
        wait_valid("satn_valid", n);
        chk("satn_y0", ych(0), -33554432);
        chk("satn_flag", bus.sat_flag, 1);
        handshake();

        // Reset mid-pass, then empty-buffer go, then identity restored
        go();
        for (int i = 0; i < 5; i++) tick();
        chk("mid_busy_pre", bus.demix_busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", bus.demix_busy, 0);
        chk("mid_y_valid", bus.y_valid, 0);
        chk("mid_cnt", bus.buf_cnt, 0);
        chk("mid_z_ready", bus.z_ready, 1);
        go();
        chk("empty_go_busy", bus.demix_busy, 0);
        tick();
        chk("empty_go_busy2", bus.demix_busy, 0);
        push(pk(65536, -32768, 16384, 0));
        go();
        wait_valid("wid_valid", n);
        chk("wid_latency", n, 17);
        chk("wid_y0", ych(0), 65536);
        chk("wid_y1", ych(1), -32768);
        chk("wid_y2", ych(2), 16384);
        chk("wid_sat", bus.sat_flag, 0);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ica_demix_stream.md
Name: ica_demix_stream

Overview:
Parametrised successor to the fixed 4-channel, 128-sample demix stage.
- Buffers a block of NCH-channel whitened samples z and holds a programmable NCH x NCH unmixing matrix W (identity after reset).
- On go_demix, streams y = W·z for every buffered sample through a valid/ready output, using one signed multiplier time-shared per MAC step.
- Sits after whitening and FastICA convergence; the controller loads W from the converged result.

Parameters:
NCH, 4, channel count (2..8)
DEPTH, 128, sample buffer depth (power of two)
DW, 26, signed sample/weight width
FRAC, 16, fractional bits of fixed-point W and z
AW, $clog2(DEPTH), derived; index width
WAW, $clog2(NCH*NCH), derived; weight address width

Ports:
clk_demix  in  1  sole clock
rst_demix  in  1  synchronous reset, active-high
z_valid  in  1  input sample valid
z_ready  out  1  buffer can accept a sample
z_data  in  NCH*DW  sample; channel 0 at LSBs
buf_clr  in  1  empty the buffer (count to 0)
buf_cnt  out  AW+1  samples stored
buf_full  out  1  buf_cnt==DEPTH
w_we  in  1  weight write strobe
w_addr  in  WAW  row*NCH+col
w_data  in  DW  weight value
go_demix  in  1  start a streaming pass (pulse)
demix_busy  out  1  pass in progress
y_valid  out  1  output sample valid
y_ready  in  1  consumer accepts
y_data  out  NCH*DW  demixed sample; channel 0 at LSBs
y_idx  out  AW  buffer index of y_data
sat_flag  out  1  sticky: any y channel saturated this pass

Behaviour:
- One clock, clk_demix. Reset rst_demix is synchronous and active-high.
- Reset effects:
  - State goes to IDLE; buf_cnt=0; all outputs 0 except z_ready=1.
  - W is set to identity: diagonal = 1<<FRAC, off-diagonal 0.
  - Sample memory contents are not reset.
- FSM states: IDLE, MAC, HOLD.
- IDLE:
  - z_ready = !buf_full.
  - z_valid&&z_ready writes z_data at address buf_cnt, then buf_cnt++.
  - w_we writes W[w_addr].
  - buf_clr sets buf_cnt=0.
  - go_demix with effective buf_cnt>0: clear sat_flag, idx=0, go to MAC.
  - go_demix with buf_cnt==0 is ignored.
- MAC:
  - Steps k = 0..NCH*NCH-1; row r = k/NCH, col c = k%NCH.
  - Each step: acc[r] += W[r][c]*Z[c][idx].
  - acc is full precision, 2*DW+$clog2(NCH) bits signed.
  - After the final step: y_ch = acc >>> FRAC (arithmetic shift, floor), saturated to [-2^(DW-1), 2^(DW-1)-1].
  - Any saturation sets sat_flag.
  - Result is registered into y_data, y_idx=idx, y_valid=1, state goes to HOLD.
- Latency: y_valid rises exactly NCH*NCH+1 edges after the edge that accepts go_demix or the previous output handshake. For NCH=4 this is 17.
- HOLD:
  - y_data and y_idx stay stable while y_valid&&!y_ready.
  - On a handshake, y_valid drops on that edge.
  - If idx==buf_cnt-1, go to IDLE. Otherwise idx++, clear acc, go to MAC.
- demix_busy = (state != IDLE).
- z_ready=0 outside IDLE. w_we, buf_clr and go_demix are ignored outside IDLE.
- Buffer is retained after a pass, so repeated go_demix re-streams the same block.
- Boundaries:
  - Full buffer: z_ready=0; z_valid is dropped with no overwrite.
  - Simultaneous z_valid write and go_demix in IDLE: the sample is stored and included in the pass.
  - buf_clr with go_demix: clear wins, go is ignored.
  - buf_clr with z_valid: clear wins, sample dropped.
  - w_we with go_demix: the write is applied before the pass uses W.
  - rst_demix mid-pass: returns to IDLE next edge, y_valid=0, W back to identity.
- y_idx wraps nowhere; a pass never exceeds buf_cnt samples.

Test Plan:
- Reset, then push z=(1.0,-0.5,0.25,0) = (65536,-32768,16384,0) for 3 samples, pulse go_demix -> y_data==z each time; y_idx 0,1,2; first y_valid 17 edges after go; demix_busy low after 3rd handshake.
- Write W[0][1]=131072 (2.0); z=(65536,32768,0,0) -> y0=131072, y1=32768, y2=y3=0; sat_flag=0.
- Hold y_ready=0 for 10 cycles on sample 0 -> y_data and y_idx constant, y_valid stays 1; release -> sample 1 follows 17 edges later.
- Push 130 samples -> z_ready falls after the 128th, buf_full=1, buf_cnt=128; samples 129–130 not stored; final y_idx=127.
- W[0][0]=2^25-1, z0=2^25-1 -> y0=33554431, sat_flag=1; negate z0 -> y0=-33554432; sat_flag clears on the next go_demix.
- Assert rst_demix at MAC step 5 -> next edge IDLE, y_valid=0, buf_cnt=0, W identity; go_demix with an empty buffer -> ignored, demix_busy stays 0.
